axis_div_responder: RTL and testbench
=====================================

Name: axis_div_responder

Overview:
- Iterative radix-2 restoring divider that is the responder side of the divider operand/result stream interface.
- Accepts dividend and divisor on two independent AXI-stream slave channels and returns a packed quotient/remainder on one master channel.
- Has no backpressure on the result channel.
- Drop-in replacement for the vendor divider core under the existing CPU divide wrappers: one instance with SIGNED=1 (DIV.W/MOD.W), one with SIGNED=0 (DIV.WU/MOD.WU).

Parameters:
- SIGNED, 1: 1 = two's-complement operands; 0 = unsigned operands.
- DATA_W, 32: operand width. Result width is 2*DATA_W.

Ports:
- aclk  input  1  clock; all state changes on its rising edge.
- aresetn  input  1  asynchronous active-low reset.
- s_axis_dividend_tvalid  input  1  dividend valid.
- s_axis_dividend_tready  output  1  dividend accept.
- s_axis_dividend_tdata  input  DATA_W  dividend.
- s_axis_divisor_tvalid  input  1  divisor valid.
- s_axis_divisor_tready  output  1  divisor accept.
- s_axis_divisor_tdata  input  DATA_W  divisor.
- m_axis_dout_tvalid  output  1  result valid, single-cycle pulse.
- m_axis_dout_tdata  output  2*DATA_W  result: [2W-1:W] = quotient, [W-1:0] = remainder.

Behaviour:
- Reset (aresetn low, asynchronous):
  - state = IDLE; got_dividend = got_divisor = 0; iteration counter = 0.
  - Both tready = 0, m_axis_dout_tvalid = 0, m_axis_dout_tdata = 0.
  - A ready-enable register (reset 0) sets on the first aclk edge after release, so tready cannot rise before then.
- tready_x = ready_en & (state==IDLE) & ~got_x, per channel.
- Handshake: channel x is captured on an edge where tvalid_x & tready_x.
  - Channels are fully independent; they may complete in the same cycle or in any order and gap.
  - Once captured, that channel's tready stays 0 until the result has been delivered.
  - tdata is sampled only at the handshake edge; later input changes are ignored.
- States:
  - IDLE: leave on the edge E where both operands are held (captured now or earlier) and go to CALC. At E, register |dividend|, |divisor|, quotient sign = sign(dividend) XOR sign(divisor), remainder sign = sign(dividend) (signs forced 0 when SIGNED=0). Clear the partial remainder and the counter.
  - CALC: one restoring step per edge at E+1..E+DATA_W. Shift {rem, quo} left 1 bit; if rem_shifted >= |divisor|, subtract it and set the quotient LSB to 1. The counter wraps from DATA_W-1, and then the state goes to FIX.
  - FIX (edge E+DATA_W+1):
    - Apply sign correction: negate the quotient if its sign is set; negate the remainder if the dividend was negative.
    - Write m_axis_dout_tdata and go to DONE.
  - DONE: m_axis_dout_tvalid = 1 for exactly this one cycle. On the next edge, return to IDLE and clear the got_* flags; tready rises in that cycle.
- Latency: tvalid is high in the cycle after edge E+DATA_W+1, i.e. 34 cycles after the last operand handshake for DATA_W=32. There is no pipelining and one division is in flight at most.
- m_axis_dout_tdata holds its value until the next FIX and is undefined-by-use when tvalid=0.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - A non-zero remainder has the dividend's sign.
  - |a| is computed in DATA_W bits: the most-negative value maps to 2^(W-1) unsigned.
- Divide by zero: no special path.
  - Result is quotient = all ones, remainder = dividend, in both modes. This is what the restoring algorithm produces.
  - For SIGNED=1 with a negative dividend, the quotient is negated to 0x00000001 by the sign rule.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- tvalid held high on a channel during CALC/FIX/DONE is not accepted, and no data is lost.
- Reset asserted mid-CALC/DONE aborts immediately: tvalid drops asynchronously and the outputs return to their reset values.

Test Plan:
- SIGNED=0, dividend 100 and divisor 7 in the same cycle -> single tvalid pulse 34 cycles later, tdata = 0x0000000E_00000002.
- SIGNED=1, -7 (0xFFFFFFF9) / 2 -> tdata = 0xFFFFFFFD_FFFFFFFF. Also 7 / -2 -> 0xFFFFFFFD_00000001.
- Staggered handshake: dividend 0xFFFFFFFF (SIGNED=0) at cycle 0, divisor 1 at cycle 5. Required response:
  - dividend_tready = 0 from cycle 1.
  - tvalid appears 34 cycles after the divisor handshake.
  - tdata = 0xFFFFFFFF_00000000.
- Corner values:
  - SIGNED=1 divide by zero, 25 / 0 -> 0xFFFFFFFF_00000019.
  - SIGNED=1 0x80000000 / -1 -> 0x80000000_00000000.
- Back-to-back with both tvalid held high continuously: the second handshake occurs exactly in the cycle after the tvalid pulse, there are no duplicate results, and the tvalid pulse width is always 1.
- Reset: aresetn low during CALC cycle 10 -> tvalid and both tready go 0 immediately and no result is emitted. After release, tready returns 1 cycle later and a new 9 / 3 yields 0x00000003_00000000.

Source files
------------

// File: rtl/axis_div_responder.sv
// rtl/axis_div_responder.sv - iterative radix-2 restoring divider, AXI-stream operand/result responder
module axis_div_responder #(
  parameter int SIGNED = 1,
  parameter int DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_dividend_tvalid,
  output logic                  s_axis_dividend_tready,
  input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
  input  logic                  s_axis_divisor_tvalid,
  output logic                  s_axis_divisor_tready,
  input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
  output logic                  m_axis_dout_tvalid,
  output logic [2*DATA_W-1:0]   m_axis_dout_tdata
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic IS_SIGNED = (SIGNED != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                ready_en_q;
  logic                got_dvd_q, got_dvd_d;
  logic                got_dvs_q, got_dvs_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;      // raw dividend captured at its handshake
  logic [DATA_W-1:0]   dvs_q, dvs_d;      // raw divisor captured at its handshake
  logic [DATA_W-1:0]   rem_q, rem_d;      // partial remainder
  logic [DATA_W-1:0]   quo_q, quo_d;      // |dividend| shifting out, quotient shifting in
  logic [DATA_W-1:0]   div_q, div_d;      // |divisor|
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] dout_q, dout_d;

  logic                dvd_hs, dvs_hs;
  logic                have_dvd, have_dvs;
  logic [DATA_W-1:0]   dvd_eff, dvs_eff;
  logic                dvd_neg, dvs_neg;
  logic [DATA_W-1:0]   dvd_abs, dvs_abs;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W-1:0]   rem_sub;
  logic                rem_ge;

  assign s_axis_dividend_tready = ready_en_q & (state_q == S_IDLE) & ~got_dvd_q;
  assign s_axis_divisor_tready  = ready_en_q & (state_q == S_IDLE) & ~got_dvs_q;
  assign m_axis_dout_tvalid     = (state_q == S_DONE);
  assign m_axis_dout_tdata      = dout_q;

  assign dvd_hs   = s_axis_dividend_tvalid & s_axis_dividend_tready;
  assign dvs_hs   = s_axis_divisor_tvalid & s_axis_divisor_tready;
  assign have_dvd = got_dvd_q | dvd_hs;
  assign have_dvs = got_dvs_q | dvs_hs;

  // An operand arriving on the same edge that completes the pair is taken straight from the bus.
  assign dvd_eff = got_dvd_q ? dvd_q : s_axis_dividend_tdata;
  assign dvs_eff = got_dvs_q ? dvs_q : s_axis_divisor_tdata;
  assign dvd_neg = IS_SIGNED & dvd_eff[DATA_W-1];
  assign dvs_neg = IS_SIGNED & dvs_eff[DATA_W-1];
  // Most-negative input maps to 2^(W-1) as an unsigned magnitude.
  assign dvd_abs = dvd_neg ? -dvd_eff : dvd_eff;
  assign dvs_abs = dvs_neg ? -dvs_eff : dvs_eff;

  // The shifted remainder needs one extra bit when the divisor is above 2^(W-1).
  assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
  assign rem_ge  = (rem_sh >= {1'b0, div_q});
  assign rem_sub = rem_sh[DATA_W-1:0] - div_q;

  // Ready enable: keeps both tready low until the first edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en_q <= 1'b0;
    else          ready_en_q <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Operand capture, divider datapath and result registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      got_dvd_q <= 1'b0;
      got_dvs_q <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      cnt_q     <= '0;
      dout_q    <= '0;
    end else begin
      got_dvd_q <= got_dvd_d;
      got_dvs_q <= got_dvs_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
    end
  end

  // Next-state and datapath update for IDLE -> CALC (W steps) -> FIX -> DONE.
  always_comb begin
    state_d   = state_q;
    got_dvd_d = got_dvd_q;
    got_dvs_d = got_dvs_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    case (state_q)
      S_IDLE: begin
        if (dvd_hs) begin
          got_dvd_d = 1'b1;
          dvd_d     = s_axis_dividend_tdata;
        end
        if (dvs_hs) begin
          got_dvs_d = 1'b1;
          dvs_d     = s_axis_divisor_tdata;
        end
        if (have_dvd && have_dvs) begin
          state_d = S_CALC;
          quo_d   = dvd_abs;
          div_d   = dvs_abs;
          rem_d   = '0;
          cnt_d   = '0;
          qneg_d  = dvd_neg ^ dvs_neg;
          rneg_d  = dvd_neg;
        end
      end
      S_CALC: begin
        quo_d = {quo_q[DATA_W-2:0], rem_ge};
        rem_d = rem_ge ? rem_sub : rem_sh[DATA_W-1:0];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIX: begin
        dout_d  = {(qneg_q ? -quo_q : quo_q), (rneg_q ? -rem_q : rem_q)};
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d   = S_IDLE;
        got_dvd_d = 1'b0;
        got_dvs_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_div_responder.sv
// tb/tb_axis_div_responder.sv - randomized self-checking bench for axis_div_responder (signed and unsigned)
module tb_axis_div_responder;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        dvd_v [2];
  logic        dvd_r [2];
  logic [31:0] dvd_d [2];
  logic        dvs_v [2];
  logic        dvs_r [2];
  logic [31:0] dvs_d [2];
  logic        dout_v [2];
  logic [63:0] dout_d [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 aclk = ~aclk;

  axis_div_responder #(.SIGNED(0), .DATA_W(32)) u_dut_u (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_dividend_tvalid (dvd_v[0]),
    .s_axis_dividend_tready (dvd_r[0]),
    .s_axis_dividend_tdata  (dvd_d[0]),
    .s_axis_divisor_tvalid  (dvs_v[0]),
    .s_axis_divisor_tready  (dvs_r[0]),
    .s_axis_divisor_tdata   (dvs_d[0]),
    .m_axis_dout_tvalid     (dout_v[0]),
    .m_axis_dout_tdata      (dout_d[0])
  );

  axis_div_responder #(.SIGNED(1), .DATA_W(32)) u_dut_s (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_dividend_tvalid (dvd_v[1]),
    .s_axis_dividend_tready (dvd_r[1]),
    .s_axis_dividend_tdata  (dvd_d[1]),
    .s_axis_divisor_tvalid  (dvs_v[1]),
    .s_axis_divisor_tready  (dvs_r[1]),
    .s_axis_divisor_tdata   (dvs_d[1]),
    .m_axis_dout_tvalid     (dout_v[1]),
    .m_axis_dout_tdata      (dout_d[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division (truncating), remainder takes dividend sign, x/0 -> q=~0 (negated for negative signed dividend), r=x.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    if (sb == 0) begin
      q = (sa < 0) ? 64'sd1 : 64'sh0000_0000_FFFF_FFFF;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {q[31:0], r[31:0]};
  endfunction

  // One division on instance m; called and returns at 1 time unit after a rising edge.
  task automatic div_op(input int m, input logic [31:0] a, input logic [31:0] b,
                        input int gap_a, input int gap_b, input logic [63:0] exp, input string tag);
    bit got_a, got_b;
    int t, n;
    got_a = 1'b0;
    got_b = 1'b0;
    t = 0;
    while (!(got_a && got_b) && t < 100) begin
      dvd_v[m] = !got_a && (t >= gap_a);
      dvd_d[m] = dvd_v[m] ? a : $urandom;
      dvs_v[m] = !got_b && (t >= gap_b);
      dvs_d[m] = dvs_v[m] ? b : $urandom;
      @(negedge aclk);
      if (got_a) check({tag, "/dvd_rdy_lo"}, 64'(dvd_r[m]), 64'd0);
      if (got_b) check({tag, "/dvs_rdy_lo"}, 64'(dvs_r[m]), 64'd0);
      if (dvd_v[m] && dvd_r[m]) got_a = 1'b1;
      if (dvs_v[m] && dvs_r[m]) got_b = 1'b1;
      @(posedge aclk);
      #1;
      t++;
    end
    dvd_v[m] = 1'b0;
    dvs_v[m] = 1'b0;
    dvd_d[m] = $urandom;
    dvs_d[m] = $urandom;
    if (!(got_a && got_b)) check({tag, "/hs_timeout"}, 64'd0, 64'd1);
    n = 1;
    while (n < 100) begin
      @(negedge aclk);
      if (dout_v[m]) break;
      check({tag, "/busy_rdy"}, 64'({dvd_r[m], dvs_r[m]}), 64'd0);
      @(posedge aclk);
      #1;
      n++;
    end
    check({tag, "/latency"}, 64'(n), 64'd34);
    check({tag, "/data"}, dout_d[m], exp);
    @(posedge aclk);
    #1;
    check({tag, "/pulse_w"}, 64'(dout_v[m]), 64'd0);
    check({tag, "/rdy_back"}, 64'({dvd_r[m], dvs_r[m]}), 64'd3);
  endtask

  // Both tvalid held high across several divisions; new operands after every handshake.
  task automatic b2b(input int m, input int nres);
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] a, b;
    int last_v, k;
    bit prev_v, hs;
    a = $urandom;
    b = $urandom_range(1, 1000);
    dvd_v[m] = 1'b1;
    dvs_v[m] = 1'b1;
    dvd_d[m] = a;
    dvs_d[m] = b;
    k = 0;
    last_v = -1;
    prev_v = 1'b0;
    for (int c = 0; c < nres * 40 + 10 && k < nres; c++) begin
      @(negedge aclk);
      hs = dvd_r[m] && dvs_r[m];
      if (dvd_r[m] || dvs_r[m]) begin
        check("b2b/hs_pair", 64'({dvd_r[m], dvs_r[m]}), 64'd3);
        if (last_v >= 0) check("b2b/hs_after_pulse", 64'(c), 64'(last_v + 1));
        if (hs) begin
          qa.push_back(a);
          qb.push_back(b);
        end
      end
      if (dout_v[m]) begin
        check("b2b/pulse_w", 64'(prev_v), 64'd0);
        if (qa.size() == 0) check("b2b/spurious", 64'd1, 64'd0);
        else check("b2b/data", dout_d[m], ref_div(m == 1, qa.pop_front(), qb.pop_front()));
        if (last_v >= 0) check("b2b/period", 64'(c - last_v), 64'd35);
        last_v = c;
        k++;
      end
      prev_v = dout_v[m];
      @(posedge aclk);
      #1;
      if (hs) begin
        a = $urandom;
        b = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(1, 50));
        dvd_d[m] = a;
        dvs_d[m] = b;
      end
    end
    dvd_v[m] = 1'b0;
    dvs_v[m] = 1'b0;
    check("b2b/count", 64'(k), 64'(nres));
    check("b2b/queue_empty", 64'(qa.size()), 64'd0);
  endtask

  initial begin
    int m, ga, gb;
    logic [31:0] a, b;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      dvd_v[i] = 1'b0;
      dvs_v[i] = 1'b0;
      dvd_d[i] = '0;
      dvs_d[i] = '0;
    end
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst/tvalid", 64'(dout_v[i]), 64'd0);
      check("rst/tready", 64'({dvd_r[i], dvs_r[i]}), 64'd0);
      check("rst/tdata", dout_d[i], 64'd0);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rst/rdy_before_edge", 64'({dvd_r[0], dvs_r[0], dvd_r[1], dvs_r[1]}), 64'd0);
    @(posedge aclk);
    #1;
    check("rst/rdy_after_edge", 64'({dvd_r[0], dvs_r[0], dvd_r[1], dvs_r[1]}), 64'hF);

    div_op(0, 32'd100, 32'd7, 0, 0, 64'h0000000E_00000002, "u_100_7");
    div_op(1, 32'hFFFFFFF9, 32'd2, 0, 0, 64'hFFFFFFFD_FFFFFFFF, "s_m7_2");
    div_op(1, 32'd7, 32'hFFFFFFFE, 0, 0, 64'hFFFFFFFD_00000001, "s_7_m2");
    div_op(0, 32'hFFFFFFFF, 32'd1, 0, 5, 64'hFFFFFFFF_00000000, "u_stagger");
    div_op(1, 32'd25, 32'd0, 0, 0, 64'hFFFFFFFF_00000019, "s_div0");
    div_op(1, 32'hFFFFFFE7, 32'd0, 2, 0, 64'h00000001_FFFFFFE7, "s_neg_div0");
    div_op(0, 32'd25, 32'd0, 0, 1, 64'hFFFFFFFF_00000019, "u_div0");
    div_op(1, 32'h80000000, 32'hFFFFFFFF, 0, 0, 64'h80000000_00000000, "s_ovf");
    div_op(1, 32'h80000000, 32'd2, 1, 0, 64'hC0000000_00000000, "s_minint_2");
    div_op(1, 32'hFFFFFF9C, 32'd7, 3, 0, 64'hFFFFFFF2_FFFFFFFE, "s_m100_7");
    div_op(0, 32'h80000000, 32'hFFFFFFFF, 0, 0, 64'h00000000_80000000, "u_big_div");

    for (int i = 0; i < 24; i++) begin
      m = int'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 16));
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      ga = int'($urandom_range(0, 3));
      gb = int'($urandom_range(0, 3));
      div_op(m, a, b, ga, gb, ref_div(m == 1, a, b), "rnd");
    end

    b2b(0, 4);
    b2b(1, 3);
    repeat (2) @(posedge aclk);
    #1;

    // Reset during CALC aborts the division.
    dvd_v[0] = 1'b1;
    dvs_v[0] = 1'b1;
    dvd_d[0] = 32'd100;
    dvs_d[0] = 32'd7;
    @(posedge aclk);
    #1;
    dvd_v[0] = 1'b0;
    dvs_v[0] = 1'b0;
    repeat (10) @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("abort/tvalid", 64'(dout_v[0]), 64'd0);
    check("abort/tready", 64'({dvd_r[0], dvs_r[0]}), 64'd0);
    check("abort/tdata", dout_d[0], 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("abort/rdy_before_edge", 64'({dvd_r[0], dvs_r[0]}), 64'd0);
    @(posedge aclk);
    #1;
    check("abort/rdy_after_edge", 64'({dvd_r[0], dvs_r[0]}), 64'd3);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (dout_v[0]) seen = 1'b1;
    end
    check("abort/no_result", 64'(seen), 64'd0);
    @(posedge aclk);
    #1;
    div_op(0, 32'd9, 32'd3, 0, 0, 64'h00000003_00000000, "u_after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
